// File: rtl/mem_if_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_if_pkg
// Brief    : Shared FSM state and response error codes for the memory
//            access initiator.
// Revision : 1.0 - initial release
// ============================================================================
package mem_if_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_WINDOW  = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mem_access_initiator.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_initiator
// Brief    : Window-checked, timeout-bounded requester for a start/ready
//            memory responder with valid/ready command and response channels.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_initiator
   import mem_if_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int WIN_LO         = 0,
   parameter int WIN_HI         = 2**ADDR_WIDTH-1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]            rsp_err,
   output logic                  mem_start,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   output logic                  mem_write_enable,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_read_data
);

   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam int              CMP_W    = ADDR_WIDTH + 2;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    we_q, we_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]              err_q, err_d;

   logic [CMP_W-1:0]        w_lo_diff;
   logic [CMP_W-1:0]        w_hi_diff;
   logic                    w_in_window;

   // Window bounds as borrow-out comparators so degenerate windows stay lint-clean
   assign w_lo_diff   = {2'b00, cmd_addr} - CMP_W'(WIN_LO);
   assign w_hi_diff   = CMP_W'(WIN_HI) - {2'b00, cmd_addr};
   assign w_in_window = !w_lo_diff[CMP_W-1] && !w_hi_diff[CMP_W-1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               if (w_in_window) begin
                  addr_d  = cmd_addr;
                  wdata_d = cmd_wdata;
                  we_d    = cmd_write;
                  state_d = ISSUE;
               end else begin
                  rdata_d = '0;
                  err_d   = ERR_WINDOW;
                  state_d = RESP;
               end
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (mem_ready) begin
               rdata_d = we_q ? '0 : mem_read_data;
               err_d   = ERR_OK;
               state_d = RESP;
            end else if (cnt_q == CNT_LAST) begin
               rdata_d = '0;
               err_d   = ERR_TIMEOUT;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
         err_q   <= ERR_OK;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign cmd_ready        = (state_q == IDLE);
   assign rsp_valid        = (state_q == RESP);
   assign mem_start        = (state_q == ISSUE);
   assign mem_address      = addr_q;
   assign mem_write_data   = wdata_q;
   assign mem_write_enable = we_q;
   assign rsp_rdata        = rdata_q;
   assign rsp_err          = err_q;

endmodule
`default_nettype wire
